// File: rtl/vga_ctrl.sv
// 640x480@60 VGA timing generator: free-running line/frame counters, sync decode,
// one-cycle-early pixel request to the picture stage and active-region rgb gating.
module vga_ctrl #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10,
  parameter int V_TOTAL = 525
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [11:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        rgb_valid,
  output logic        frame_start
);

  localparam logic [9:0] H_SW   = 10'(H_SYNC);
  localparam logic [9:0] V_SW   = 10'(V_SYNC);
  localparam logic [9:0] HS     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HE     = 10'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0] HR_S   = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] HR_E   = 10'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [9:0] VS     = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VE     = 10'(V_SYNC + V_BACK + V_VALID);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [9:0] cnt_h, cnt_v;
  logic       h_act, v_act, h_req, pix_req;

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_LAST) ? 10'd0 : cnt_v + 10'd1;
    end else begin
      cnt_h <= cnt_h + 10'd1;
    end
  end

  // Request window leads the display window by one clock to cover the
  // registered latency of the picture stage.
  always_comb begin
    h_act       = (cnt_h >= HS) && (cnt_h < HE);
    v_act       = (cnt_v >= VS) && (cnt_v < VE);
    h_req       = (cnt_h >= HR_S) && (cnt_h < HR_E);
    pix_req     = h_req && v_act;
    rgb_valid   = h_act && v_act;
    hsync       = (cnt_h >= H_SW);
    vsync       = (cnt_v >= V_SW);
    pix_x       = pix_req ? cnt_h - HR_S : 10'h3FF;
    pix_y       = pix_req ? cnt_v - VS : 10'h3FF;
    rgb         = rgb_valid ? pix_data : 12'h000;
    frame_start = (cnt_h == 10'd0) && (cnt_v == 10'd0) && !sys_rst;
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// Self-checking bench for vga_ctrl on a scaled-down raster; a picture-stage model
// feeds pix_data and a scoreboard queue checks request/display alignment.
module tb_vga_ctrl;
  localparam int HSY = 8, HBK = 6, HVL = 32, HFR = 4, HTT = 50;
  localparam int VSY = 2, VBK = 3, VVL = 20, VFR = 2, VTT = 27;
  localparam int HS = HSY + HBK, VS = VSY + VBK, FRAME = HTT * VTT;

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [11:0] pix_data = 12'h000;
  logic [9:0]  pix_x, pix_y;
  logic        hsync, vsync, rgb_valid, frame_start;
  logic [11:0] rgb;

  int total = 0, bad = 0;
  int m_h = 0, m_v = 0;
  int mode = 2;  // 0 coordinate pattern, 1 all-ones, 2 constant 0xABC
  logic [11:0] sb[$];

  vga_ctrl #(
    .H_SYNC(HSY), .H_BACK(HBK), .H_VALID(HVL), .H_FRONT(HFR), .H_TOTAL(HTT),
    .V_SYNC(VSY), .V_BACK(VBK), .V_VALID(VVL), .V_FRONT(VFR), .V_TOTAL(VTT)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .rgb_valid(rgb_valid), .frame_start(frame_start)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [11:0] pat(input logic [9:0] x, input logic [9:0] y);
    return {2'b00, y[4:0], x[4:0]};
  endfunction

  // One clock: picture stage registers the request seen before the edge,
  // reference counters advance, and we return at the next falling edge.
  task automatic step();
    logic [9:0] rx, ry;
    logic req;
    rx = pix_x; ry = pix_y; req = (pix_x != 10'h3FF);
    if (req) sb.push_back(mode == 1 ? 12'hFFF : mode == 2 ? 12'hABC : pat(rx, ry));
    @(posedge vga_clk);
    if (sys_rst) begin
      m_h = 0; m_v = 0; sb.delete();
    end else if (m_h == HTT - 1) begin
      m_h = 0; m_v = (m_v == VTT - 1) ? 0 : m_v + 1;
    end else m_h++;
    #1;
    pix_data = (mode == 1) ? 12'hFFF : (mode == 2) ? 12'hABC :
               (req ? pat(rx, ry) : 12'($urandom));
    @(negedge vga_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    repeat (20) step();
    sys_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({rgb, pix_x, pix_y, hsync, vsync, frame_start, rgb_valid} !==
          {12'h000, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d rgb=%h x=%h y=%h hs=%b vs=%b fs=%b val=%b need 000/3ff/3ff/0/0/0/0",
                 i, rgb, pix_x, pix_y, hsync, vsync, frame_start, rgb_valid);
      end
    end
    sys_rst = 1'b0;
    #1;
    total++;
    if ({frame_start, hsync, vsync, rgb} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
      bad++;
      $display("FAIL reset_release fs=%b hs=%b vs=%b rgb=%h need 1/0/0/000", frame_start, hsync, vsync, rgb);
    end
    step();
    total++;
    if (frame_start !== 1'b0) begin
      bad++; $display("FAIL reset_pulse_width fs=%b need 0", frame_start);
    end
  endtask

  task automatic test_frame();
    int n, vlow, vcnt, lines, hs_run, last_x;
    logic prev_hs, line_val;
    logic e_hs, e_vs, e_val, e_fs, e_req;
    logic [9:0] e_x, e_y;
    logic [11:0] e_rgb;
    mode = 0;
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * FRAME) begin step(); n++; end
    total++;
    if (frame_start !== 1'b1) begin bad++; $display("FAIL frame_sync timeout n=%0d", n); end
    prev_hs = hsync; hs_run = 0;
    for (int f = 0; f < 2; f++) begin
      vlow = 0; vcnt = 0; lines = 0; line_val = 1'b0; last_x = -1;
      for (int c = 0; c < FRAME; c++) begin
        e_hs  = !(m_h < HSY);
        e_vs  = !(m_v < VSY);
        e_val = (m_h >= HS) && (m_h < HS + HVL) && (m_v >= VS) && (m_v < VS + VVL);
        e_req = (m_h >= HS - 1) && (m_h < HS + HVL - 1) && (m_v >= VS) && (m_v < VS + VVL);
        e_fs  = (m_h == 0) && (m_v == 0);
        e_x   = e_req ? 10'(m_h - (HS - 1)) : 10'h3FF;
        e_y   = e_req ? 10'(m_v - VS) : 10'h3FF;
        total++;
        if ({hsync, vsync, rgb_valid, frame_start} !== {e_hs, e_vs, e_val, e_fs}) begin
          bad++;
          $display("FAIL ctl h=%0d v=%0d got hs/vs/val/fs=%b%b%b%b need %b%b%b%b",
                   m_h, m_v, hsync, vsync, rgb_valid, frame_start, e_hs, e_vs, e_val, e_fs);
        end
        total++;
        if ({pix_x, pix_y} !== {e_x, e_y}) begin
          bad++;
          $display("FAIL req h=%0d v=%0d got x=%h y=%h need x=%h y=%h", m_h, m_v, pix_x, pix_y, e_x, e_y);
        end
        total++;
        if (rgb_valid === 1'b1) begin
          if (sb.size() == 0) begin
            bad++; $display("FAIL sb_empty h=%0d v=%0d rgb=%h", m_h, m_v, rgb);
          end else begin
            e_rgb = sb.pop_front();
            if (rgb !== e_rgb) begin
              bad++; $display("FAIL rgb_data h=%0d v=%0d got %h need %h", m_h, m_v, rgb, e_rgb);
            end
          end
        end else if (rgb !== 12'h000) begin
          bad++; $display("FAIL rgb_blank h=%0d v=%0d got %h need 000", m_h, m_v, rgb);
        end
        if (m_v == VS && m_h == HS) begin
          total++;
          if (rgb !== 12'h000) begin bad++; $display("FAIL align_00 got %h need 000", rgb); end
        end
        if (m_v == VS + 1 && m_h == HS + 1) begin
          total++;
          if (rgb !== 12'h021) begin bad++; $display("FAIL align_11 got %h need 021", rgb); end
        end
        if (pix_x !== 10'h3FF) last_x = int'(pix_x);
        if (!vsync) vlow++;
        if (rgb_valid) begin vcnt++; line_val = 1'b1; end
        if (hsync !== prev_hs) begin
          total++;
          if (hs_run != (prev_hs ? HTT - HSY : HSY) && !(f == 0 && c == 0)) begin
            bad++; $display("FAIL hsync_run lvl=%b got %0d", prev_hs, hs_run);
          end
          hs_run = 0;
        end
        prev_hs = hsync; hs_run++;
        if (m_h == HTT - 1) begin
          if (line_val) begin
            lines++;
            total++;
            if (last_x != HVL - 1) begin
              bad++; $display("FAIL last_req v=%0d got %0d need %0d", m_v, last_x, HVL - 1);
            end
          end
          line_val = 1'b0; last_x = -1;
        end
        step();
      end
      total++;
      if (frame_start !== 1'b1) begin bad++; $display("FAIL frame_period f=%0d fs=%b need 1", f, frame_start); end
      total++;
      if (vlow != VSY * HTT) begin bad++; $display("FAIL vsync_low got %0d need %0d", vlow, VSY * HTT); end
      total++;
      if (vcnt != HVL * VVL) begin bad++; $display("FAIL valid_clks got %0d need %0d", vcnt, HVL * VVL); end
      total++;
      if (lines != VVL) begin bad++; $display("FAIL valid_lines got %0d need %0d", lines, VVL); end
    end
  endtask

  task automatic test_blank();
    logic e_val;
    mode = 1;
    for (int c = 0; c < FRAME; c++) begin
      e_val = (m_h >= HS) && (m_h < HS + HVL) && (m_v >= VS) && (m_v < VS + VVL);
      total++;
      if ({rgb_valid, rgb} !== {e_val, e_val ? 12'hFFF : 12'h000}) begin
        bad++;
        $display("FAIL blank h=%0d v=%0d got val=%b rgb=%h need val=%b", m_h, m_v, rgb_valid, rgb, e_val);
      end
      if (rgb_valid === 1'b1 && sb.size() != 0) void'(sb.pop_front());
      step();
    end
    sb.delete();
  endtask

  task automatic test_mid_reset();
    int n;
    mode = 0;
    n = 0;
    while (!(m_v == 12 && m_h == 25) && n < 2 * FRAME) begin step(); n++; end
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    #1;
    total++;
    if ({hsync, vsync, frame_start, pix_x, rgb_valid} !== {1'b0, 1'b0, 1'b1, 10'h3FF, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset hs=%b vs=%b fs=%b x=%h val=%b need 0/0/1/3ff/0",
               hsync, vsync, frame_start, pix_x, rgb_valid);
    end
    n = 0;
    do begin step(); n++; end while (frame_start !== 1'b1 && n <= 2 * FRAME);
    total++;
    if (n != FRAME) begin bad++; $display("FAIL mid_reset_period got %0d need %0d", n, FRAME); end
  endtask

  initial begin
    sys_rst = 1'b1;
    mode = 2;
    @(negedge vga_clk);
    repeat (3) step();
    test_reset();
    test_frame();
    test_blank();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
